// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N_REQ producers
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic [N_REQ-1:0]          i_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_wrdata,
  output logic [N_REQ-1:0]          o_ready,
  input  logic                      i_full,
  output logic                      o_wren,
  output logic [DATA_W-1:0]         o_wrdata,
  output logic [N_REQ-1:0]          o_grant,
  output logic [$clog2(N_REQ)-1:0]  o_gnt_id
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, sel, idx;
  logic [BW-1:0] beat_cnt;
  logic found, busy, last;
  assign busy = state == GRANT;
  assign o_ready = (busy && i_en && !i_full) ? o_grant : '0;
  assign o_wren = busy && i_en && !i_full && i_valid[o_gnt_id];
  assign o_wrdata = busy ? i_wrdata[o_gnt_id*DATA_W +: DATA_W] : '0;
  assign last = o_wren && beat_cnt == BW'(BURST_MAX - 1);
  always_comb begin
    sel = '0;
    idx = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % N_REQ);
      if (i_valid[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      o_gnt_id <= '0;
      o_grant <= '0;
      beat_cnt <= '0;
    end else if (i_en) begin
      if (!busy) begin
        if (found) begin
          state <= GRANT;
          o_gnt_id <= sel;
          o_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
          beat_cnt <= '0;
        end
      end else if (last || !i_valid[o_gnt_id]) begin
        state <= IDLE;
        o_gnt_id <= '0;
        o_grant <= '0;
        beat_cnt <= '0;
        rr_ptr <= (o_gnt_id == IW'(N_REQ - 1)) ? '0 : o_gnt_id + 1'b1;
      end else if (o_wren) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of a RAM-based FIFO between N_REQ independent producers.
- Each producer presents data with a valid/ready handshake.
- The arbiter grants one producer at a time for a burst of up to BURST_MAX beats, then drives the FIFO write enable and write data.
- Sits directly in front of the FIFO enqueue side and consumes its full flag.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_W, 8, data width per requester and of the FIFO write port
BURST_MAX, 4, maximum beats per grant before forced re-arbitration (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
i_en  input  1  arbiter enable; low freezes all state and suppresses writes
i_valid  input  N_REQ  per-requester data valid
i_wrdata  input  N_REQ*DATA_W  per-requester data, requester k at bits [k*DATA_W +: DATA_W]
o_ready  output  N_REQ  per-requester accept; a beat transfers when i_valid[k] & o_ready[k]
i_full  input  1  FIFO full flag
o_wren  output  1  FIFO write enable
o_wrdata  output  DATA_W  FIFO write data
o_grant  output  N_REQ  one-hot registered grant, all zero when idle
o_gnt_id  output  $clog2(N_REQ)  index of current grantee, 0 when idle

Behaviour:
- Reset: all outputs low/zero, including o_grant, o_gnt_id, o_wren and o_ready. State=IDLE, rr_ptr=0, beat_cnt=0. Reset has priority over i_en and aborts any burst in progress.
- Counter widths: rr_ptr is $clog2(N_REQ) bits; beat_cnt is $clog2(BURST_MAX+1) bits.
- States: IDLE, GRANT.
- IDLE, with i_en=1 and any i_valid set:
  - Select the first k with i_valid[k]=1, searching k = rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ.
  - Next cycle: state=GRANT, o_grant=onehot(k), o_gnt_id=k, beat_cnt=0.
  - Latency from valid to grant is 1 cycle. No transfer occurs in IDLE.
- GRANT with grantee g, all outputs combinational from registered g:
  - o_ready[g] = i_en & !i_full; every other o_ready bit is 0.
  - o_wren = i_en & i_valid[g] & !i_full.
  - o_wrdata = i_wrdata[g] whenever in GRANT. o_wrdata is 0 in IDLE.
- Per-beat (o_wren=1): beat_cnt increments.
- Release: the cycle after either condition below, state=IDLE, o_grant=0, and rr_ptr = (g+1) mod N_REQ, with wrap at N_REQ-1 to 0.
  - A beat transfers with beat_cnt == BURST_MAX-1.
  - i_en=1 and i_valid[g]=0.
- Re-arbitration gap: one IDLE cycle between bursts, even when others are waiting.
- i_full=1 in GRANT: no transfer, beat_cnt and grant held. If the grantee drops valid while full, release still occurs.
- i_en=0: state, grant, rr_ptr and beat_cnt frozen; o_wren=0; o_ready=0. Resume exactly where left off.
- A requester's valid deasserting mid-burst is legal. A valid bit is never sampled for a non-granted requester except in IDLE selection.
- The arbiter never drives o_wren while i_full=1, so the FIFO never sees a dropped write.
- Fairness: a requester continuously asserting valid is granted within N_REQ-1 bursts.

Test Plan:
- Reset then single requester: N_REQ=4, BURST_MAX=4, i_valid=0001 with data 0x10..0x15 -> o_grant=0001 one cycle after valid. Writes 0x10..0x13 on 4 consecutive o_wren cycles, 1 idle cycle, then regrant to 0 for 0x14, 0x15.
- All four valid continuously -> grant order 0,1,2,3,0. Each burst is exactly 4 beats, one IDLE cycle between bursts, and o_wrdata always matches the grantee's data.
- Backpressure: i_full=1 for 3 cycles mid-burst after beat 2 -> o_wren=0 and o_ready=0 during those cycles, grant held, and beats 3-4 complete after i_full falls. The FIFO receives exactly 4 writes.
- Early release: grantee 2 drops valid after 1 beat while requester 3 is valid -> IDLE next cycle, then grant=1000, rr_ptr=3.
- Wrap: rr_ptr=3, only requesters 0 and 3 valid -> 3 granted first, then 0. Confirms modulo search and pointer wrap.
- i_en low mid-burst for 5 cycles, then rst pulsed mid-burst -> no o_wren while disabled and the burst resumes with the same beat_cnt. After rst, outputs are zero and the next grant starts the search from requester 0.
